// File: rtl/draw_pkg.sv
// draw_pkg: shared geometry defaults, colour/box types and coordinate helpers for the overlay box path
package draw_pkg;
  localparam logic [11:0] H_ACT_D = 12'd1280;
  localparam logic [11:0] V_ACT_D = 12'd720;
  localparam int HB = $clog2(H_ACT_D);
  localparam int VB = $clog2(V_ACT_D);
  typedef logic [23:0] rgb_t;
  typedef struct packed {
    logic [HB-1:0] sx;
    logic [VB-1:0] sy;
    logic [HB-1:0] ex;
    logic [VB-1:0] ey;
    rgb_t          color;
  } box_t;
  function automatic logic box_bad(logic [11:0] sx, logic [11:0] ex, logic [11:0] sy, logic [11:0] ey);
    return (sx > ex) || (sy > ey);
  endfunction
  function automatic logic box_null(logic [11:0] sx, logic [11:0] ex, logic [11:0] sy, logic [11:0] ey);
    return (sx | ex | sy | ey) == 12'd0;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant of one requester per cycle
// ports: clk/rst, req (N requests), en (grant enable), grant (one-hot), grant_idx (granted index)
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] r_ptr;
  logic          w_hit;
  // scan downwards so the requester nearest ptr is the last (winning) assignment
  always_comb begin
    w_hit     = 1'b0;
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(r_ptr) + i) % N]) begin
        w_hit     = 1'b1;
        grant_idx = IW'((int'(r_ptr) + i) % N);
      end
  end
  assign grant = (en && w_hit) ? N'(1) << grant_idx : '0;
  always_ff @(posedge clk)
    if (rst) r_ptr <= '0;
    else if (en && w_hit) r_ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/box_table_ctrl.sv
// box_table_ctrl: arbitrated box writes into a shadow table, committed atomically on vsync rise with per-slot ageing
// ports: clk/rst, vsync (frame boundary on rise), req_* (N_REQ packed write requests, req_ready grant),
//        start_xs/end_xs/start_ys/end_ys/colors (committed N_BOX table), frame_commit, err_drop (pulses)
module box_table_ctrl
  import draw_pkg::*;
#(
  parameter int          N_BOX   = 4,
  parameter int          N_REQ   = 2,
  parameter logic [11:0] H_ACT   = H_ACT_D,
  parameter logic [11:0] V_ACT   = V_ACT_D,
  parameter int          MAX_AGE = 8,
  localparam int XB = $clog2(H_ACT),
  localparam int YB = $clog2(V_ACT),
  localparam int SB = N_BOX > 1 ? $clog2(N_BOX) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vsync,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*SB-1:0] req_slot,
  input  logic [N_REQ*XB-1:0] req_sx,
  input  logic [N_REQ*XB-1:0] req_ex,
  input  logic [N_REQ*YB-1:0] req_sy,
  input  logic [N_REQ*YB-1:0] req_ey,
  input  logic [N_REQ*24-1:0] req_color,
  output logic [N_BOX*XB-1:0] start_xs,
  output logic [N_BOX*XB-1:0] end_xs,
  output logic [N_BOX*YB-1:0] start_ys,
  output logic [N_BOX*YB-1:0] end_ys,
  output logic [N_BOX*24-1:0] colors,
  output logic                frame_commit,
  output logic                err_drop
);
  localparam int AW = MAX_AGE > 0 ? $clog2(MAX_AGE + 1) : 1;
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  typedef struct packed {
    logic [XB-1:0] sx;
    logic [YB-1:0] sy;
    logic [XB-1:0] ex;
    logic [YB-1:0] ey;
    rgb_t          color;
  } slot_t;
  logic          r_vq, r_commit, r_drop;
  slot_t         r_sh [N_BOX];
  slot_t         r_out [N_BOX];
  logic [AW-1:0] r_age [N_BOX];
  logic [AW-1:0] w_age_n [N_BOX];
  logic [N_BOX-1:0] r_fresh, w_exp;
  logic          w_rise, w_acc, w_bad, w_null;
  logic [IW-1:0] w_idx;
  logic [SB-1:0] w_slot;
  slot_t         w_box;
  assign w_rise = vsync & ~r_vq;
  // holding off grants in the rise cycle keeps writes and commits disjoint
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk(clk), .rst(rst), .req(req_valid), .en(~w_rise), .grant(req_ready), .grant_idx(w_idx)
  );
  assign w_acc  = |req_ready;
  assign w_slot = req_slot[int'(w_idx)*SB +: SB];
  assign w_box  = {req_sx[int'(w_idx)*XB +: XB], req_sy[int'(w_idx)*YB +: YB],
                   req_ex[int'(w_idx)*XB +: XB], req_ey[int'(w_idx)*YB +: YB],
                   req_color[int'(w_idx)*24 +: 24]};
  assign w_null = box_null(12'(w_box.sx), 12'(w_box.ex), 12'(w_box.sy), 12'(w_box.ey));
  assign w_bad  = int'(w_slot) >= N_BOX || box_bad(12'(w_box.sx), 12'(w_box.ex), 12'(w_box.sy), 12'(w_box.ey));
  // age saturates at MAX_AGE; reaching it expires the slot on the same commit
  always_comb
    for (int i = 0; i < N_BOX; i++) begin
      w_age_n[i] = r_fresh[i] ? '0 :
                   (r_sh[i] != '0 && MAX_AGE != 0 && r_age[i] != AW'(MAX_AGE)) ? r_age[i] + 1'b1 : r_age[i];
      w_exp[i]   = MAX_AGE != 0 && w_age_n[i] == AW'(MAX_AGE);
    end
  always_ff @(posedge clk)
    if (rst) begin
      r_vq     <= 1'b0;
      r_commit <= 1'b0;
      r_drop   <= 1'b0;
      r_fresh  <= '0;
      for (int i = 0; i < N_BOX; i++) begin
        r_sh[i]  <= '0;
        r_out[i] <= '0;
        r_age[i] <= '0;
      end
    end else begin
      r_vq     <= vsync;
      r_commit <= w_rise;
      r_drop   <= w_acc & w_bad;
      if (w_rise) begin
        r_fresh <= '0;
        for (int i = 0; i < N_BOX; i++) begin
          r_age[i] <= w_age_n[i];
          r_out[i] <= w_exp[i] ? '0 : r_sh[i];
          if (w_exp[i]) r_sh[i] <= '0;
        end
      end else if (w_acc && !w_bad) begin
        r_sh[w_slot]    <= w_null ? '0 : w_box;
        r_fresh[w_slot] <= ~w_null;
      end
    end
  for (genvar i = 0; i < N_BOX; i++) begin : g_out
    assign start_xs[i*XB +: XB] = r_out[i].sx;
    assign end_xs[i*XB +: XB]   = r_out[i].ex;
    assign start_ys[i*YB +: YB] = r_out[i].sy;
    assign end_ys[i*YB +: YB]   = r_out[i].ey;
    assign colors[i*24 +: 24]   = r_out[i].color;
  end
  assign frame_commit = r_commit;
  assign err_drop     = r_drop;
endmodule
